// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default bit timing and data width.
// Used by both the transmitter and the receive controller.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 5208;
  localparam int unsigned DATA_W               = 8;
  localparam int unsigned IDX_W                = $clog2(DATA_W);
  localparam int unsigned TIMER_W              = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_CLEANUP = 3'd4,
    ST_PARITY  = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter: pulses tick_o when the count reaches CLKS_PER_BIT-1,
// then restarts from zero. clr_i holds the count at zero.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(CLKS_PER_BIT - 1);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  // Restarting at LAST keeps the counter from ever wrapping through 2^16.
  always_comb begin
    cnt_d = cnt_q + TIMER_W'(1);
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, all outputs registered.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              TX_START,
  output logic              UART_TXD,
  output logic              TX_BUSY,
  output logic              TX_DONE
);

  uart_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              txd_q, txd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              timer_clr;
  logic              bit_tick;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk_i (CLOCK_50),
    .srst_i(RESET),
    .clr_i (timer_clr),
    .tick_o(bit_tick)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    timer_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_clr = 1'b1;
        idx_d     = '0;
        if (TX_START) begin
          shift_d = TX_DATA;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_tick) begin
          if (idx_q == IDX_W'(DATA_W - 1)) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_tick) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (bit_tick) state_d = ST_CLEANUP;
      end
      ST_CLEANUP: begin
        timer_clr = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        timer_clr = 1'b1;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // Outputs are a registered image of the current state, so the line lags the FSM by one cycle.
  always_comb begin
    txd_d  = 1'b1;
    busy_d = (state_q != ST_IDLE);
    done_d = (state_q == ST_CLEANUP);
    case (state_q)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_q[idx_q];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_d = ^shift_q;
`endif
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign UART_TXD = txd_q;
  assign TX_BUSY  = busy_q;
  assign TX_DONE  = done_q;

endmodule
